// File: rtl/clkdiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clkdiv_pkg                                                      |
// | Brief    : Shared mode type and parameter limits for the clock divider.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package clkdiv_pkg;

    typedef enum logic {
        TOGGLE = 1'b0,
        PULSE  = 1'b1
    } mode_t;

    localparam int c_ch_idx_w   = 4;
    localparam int c_num_ch_min = 1;
    localparam int c_num_ch_max = 1 << c_ch_idx_w;
    localparam int c_cnt_w_min  = 2;
    localparam int c_cnt_w_max  = 16;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clkdiv_channel                                                  |
// | Brief    : One divider channel: divisor, counter, pending config, apply.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sync,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_div,
    input  mode_t            i_wr_mode,
    output logic             o_pend,
    output logic             o_clk_out,
    output logic             o_tick
);

    logic [CNT_W-1:0] div_q,  div_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    mode_t            mode_q, mode_d;
    mode_t            pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic w_stopped;
    logic w_boundary;
    logic w_apply;

    assign w_stopped  = (div_q == '0);
    assign w_boundary = !w_stopped && (cnt_q == div_q - CNT_W'(1));
    assign w_apply    = pend_q && (w_boundary || w_stopped);

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pdiv_d    = pdiv_q;
        pmode_d   = pmode_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        // Writes are only offered while nothing is pending, so they never race an apply.
        if (i_wr_en && !pend_q) begin
            pdiv_d  = i_wr_div;
            pmode_d = i_wr_mode;
            pend_d  = 1'b1;
        end

        if (i_sync) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else begin
            if (w_stopped) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end else if (w_boundary) begin
                cnt_d     = '0;
                tick_d    = 1'b1;
                clk_out_d = (mode_q == PULSE) ? 1'b1 : ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mode_q == PULSE) begin
                    clk_out_d = 1'b0;
                end
            end

            // Same mode and nonzero divisor: the output phase carries straight on.
            if (w_apply) begin
                div_d  = pdiv_q;
                mode_d = pmode_q;
                cnt_d  = '0;
                pend_d = 1'b0;
                if ((pmode_q != mode_q) || (pdiv_q == '0)) begin
                    clk_out_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= CNT_W'(DEFAULT_DIV);
            mode_q    <= TOGGLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pdiv_q    <= '0;
            pmode_q   <= TOGGLE;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pdiv_q    <= pdiv_d;
            pmode_q   <= pmode_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign o_pend    = pend_q;
    assign o_clk_out = clk_out_q;
    assign o_tick    = tick_q;

endmodule : clkdiv_channel
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multi_clock_divider                                             |
// | Brief    : NUM_CH independent clock dividers with a shared config port.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    if ((NUM_CH < c_num_ch_min) || (NUM_CH > c_num_ch_max)) begin : g_bad_num_ch
        $error("multi_clock_divider: NUM_CH out of range");
    end
    if ((CNT_W < c_cnt_w_min) || (CNT_W > c_cnt_w_max)) begin : g_bad_cnt_w
        $error("multi_clock_divider: CNT_W out of range");
    end

    logic [NUM_CH-1:0]       w_pend;
    logic [NUM_CH-1:0]       w_wr_en;
    logic [c_num_ch_max-1:0] w_pend_ext;
    logic                    w_in_range;
    logic                    w_accept;
    logic                    cfg_err_q, cfg_err_d;

    // Zero-extending pend lets cfg_ch index safely even for small NUM_CH.
    assign w_pend_ext = c_num_ch_max'(w_pend);
    assign w_in_range = (32'(cfg_ch) < 32'(NUM_CH));
    assign cfg_ready  = w_in_range ? ~w_pend_ext[cfg_ch] : 1'b1;
    assign w_accept   = cfg_valid && cfg_ready;

    always_comb begin
        cfg_err_d = w_accept && !w_in_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr_en[i] = w_accept && w_in_range && (cfg_ch == 4'(i));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk       (clk),
            .rst       (reset),
            .i_sync    (sync),
            .i_wr_en   (w_wr_en[i]),
            .i_wr_div  (cfg_div),
            .i_wr_mode (mode_t'(cfg_mode)),
            .o_pend    (w_pend[i]),
            .o_clk_out (clk_out[i]),
            .o_tick    (tick[i])
        );
    end

endmodule : multi_clock_divider
`default_nettype wire

// File: tb/tb_multi_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multi_clock_divider                                          |
// | Brief    : Directed self-checking bench for multi_clock_divider.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_multi_clock_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic       cfg_err;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int n;
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] e_clk;
    logic [3:0] e_tick;

    multi_clock_divider #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .DEFAULT_DIV (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic write(input logic [3:0] ch, input logic [7:0] dv, input logic md);
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_mode  = md;
        cfg_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 4'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
        n = 0;

        // Reset state
        step(); step();
        chk("rst clk_out", clk_out, 4'b0000);
        chk("rst tick", tick, 4'b0000);
        chk("rst cfg_err", cfg_err, 1'b0);
        chk("rst cfg_ready", cfg_ready, 1'b1);

        // Default divisor 8 TOGGLE on all channels
        reset = 1'b0;
        n = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk("def tick", tick, (n % 8 == 0) ? 4'b1111 : 4'b0000);
            chk("def clk", clk_out, ((n / 8) % 2 == 1) ? 4'b1111 : 4'b0000);
        end

        // ch1 -> div 3 PULSE mid-period, applies at the boundary feeding edge 32
        step(); step(); step();
        write(4'd1, 8'd3, 1'b1);
        #1;
        chk("p2 ready pre", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        for (int k = 28; k <= 42; k++) begin
            if (k > 28) step();
            e_tick    = (n % 8 == 0) ? 4'b1101 : 4'b0000;
            e_clk     = ((n / 8) % 2 == 1) ? 4'b1101 : 4'b0000;
            e_tick[1] = (n == 32) || (n == 35) || (n == 38) || (n == 41);
            e_clk[1]  = (n < 32) || (n == 35) || (n == 38) || (n == 41);
            chk("p2 tick", tick, e_tick);
            chk("p2 clk", clk_out, e_clk);
            chk("p2 ready", cfg_ready, (n >= 32));
        end

        // ch2 -> div 0 stops at boundary 48, then div 2 applies the next cycle
        write(4'd2, 8'd0, 1'b0);
        #1;
        chk("p3 ready pre", cfg_ready, 1'b1);
        for (int k = 43; k <= 52; k++) begin
            step();
            cfg_valid = 1'b0;
            chk("p3 clk2 stop", clk_out[2], (n < 48));
            if (n > 48) chk("p3 tick2 stop", tick[2], 1'b0);
        end
        write(4'd2, 8'd2, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("p3 ready busy", cfg_ready, 1'b0);
        for (int k = 53; k <= 61; k++) begin
            if (k > 53) step();
            if (n == 54) chk("p3 ready free", cfg_ready, 1'b1);
            chk("p3 clk2 div2", clk_out[2], (n == 56) || (n == 57) || (n == 60) || (n == 61));
            chk("p3 tick2 div2", tick[2], (n == 56) || (n == 58) || (n == 60));
        end

        // ch2 -> div 5, then sync with a same-cycle write to ch3
        write(4'd2, 8'd5, 1'b0);
        step();
        cfg_valid = 1'b0;
        repeat (8) step();
        sync = 1'b1;
        write(4'd3, 8'd4, 1'b0);
        step();
        sync = 1'b0;
        cfg_valid = 1'b0;
        chk("sync clk", clk_out, 4'b0000);
        chk("sync tick", tick, 4'b0000);
        chk("sync ready3", cfg_ready, 1'b0);
        for (int k = 72; k <= 79; k++) begin
            step();
            e_tick[0] = (n == 79);
            e_tick[1] = ((n - 71) % 3 == 0);
            e_tick[2] = (n == 76);
            e_tick[3] = (n == 79);
            e_clk[0]  = (n >= 79);
            e_clk[1]  = e_tick[1];
            e_clk[2]  = (n >= 76);
            e_clk[3]  = (n >= 79);
            chk("post-sync tick", tick, e_tick);
            chk("post-sync clk", clk_out, e_clk);
            chk("post-sync ready3", cfg_ready, (n >= 79));
        end

        // Out-of-range write
        chk("err idle", cfg_err, 1'b0);
        write(4'd9, 8'd1, 1'b0);
        #1;
        chk("oor ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("oor err pulse", cfg_err, 1'b1);
        step();
        chk("oor err clear", cfg_err, 1'b0);
        repeat (6) step();
        chk("oor tick87", tick, 4'b1001);
        chk("oor clk87", clk_out, 4'b1100);

        // Reset mid-period with ch1 pending; write presented during reset is dropped
        write(4'd1, 8'd7, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("p6 ready busy", cfg_ready, 1'b0);
        reset = 1'b1;
        sync  = 1'b1;
        write(4'd2, 8'd1, 1'b0);
        step();
        chk("p6 rst clk", clk_out, 4'b0000);
        chk("p6 rst tick", tick, 4'b0000);
        chk("p6 rst err", cfg_err, 1'b0);
        reset = 1'b0;
        sync  = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = 4'd1;
        #1;
        chk("p6 ready1", cfg_ready, 1'b1);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("p6 tick", tick, (n == 8) ? 4'b1111 : 4'b0000);
            chk("p6 clk", clk_out, (n >= 8) ? 4'b1111 : 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_multi_clock_divider
`default_nettype wire
